// File: rtl/ram_4k_arbiter.sv
// Dual-port round-robin arbiter in front of a 4K-word RAM: two writers and two
// readers, read responses routed back in issue order through a tag FIFO.
module ram_4k_arbiter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 12,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wr_req,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            wr_gnt,
  input  logic [1:0]            rd_req,
  input  logic [2*ADDR_W-1:0]   rd_addr,
  output logic [1:0]            rd_gnt,
  output logic [1:0]            rd_rsp_valid,
  output logic [DATA_W-1:0]     rd_rsp_data,
  output logic                  ram_write,
  output logic [ADDR_W-1:0]     ram_wr_address,
  output logic [DATA_W-1:0]     ram_data_in,
  output logic                  ram_read,
  output logic [ADDR_W-1:0]     ram_rd_address,
  input  logic [DATA_W-1:0]     ram_data_out,
  input  logic                  ram_data_valid,
  output logic                  rsp_err
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(TAG_DEPTH);

  function automatic logic [1:0] rr(input logic [1:0] req, input logic ptr);
    if (req == 2'b11) return ptr ? 2'b10 : 2'b01;
    return req;
  endfunction

  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic              ram_write_q, ram_read_q, rsp_err_q;
  logic [ADDR_W-1:0] wa_q, ra_q, wsel_addr, rsel_addr;
  logic [DATA_W-1:0] wd_q, rsp_data_q;
  logic [1:0]        rsp_vld_q, rd_cand;
  logic              tag_q [TAG_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [PW:0]       cnt_q;
  logic              hazard, full, push, pop;

  always_comb begin
    wr_gnt    = rst ? 2'b00 : rr(wr_req, wptr_q);
    wsel_addr = wr_gnt[1] ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    rd_cand   = rr(rd_req, rptr_q);
    rsel_addr = rd_cand[1] ? rd_addr[2*ADDR_W-1:ADDR_W] : rd_addr[ADDR_W-1:0];
    // a read racing a write to the same word waits one cycle so it sees the new data
    hazard    = (|wr_gnt) && (|rd_cand) && (rsel_addr == wsel_addr);
    full      = (cnt_q == FULL);
    pop       = ram_data_valid && (cnt_q != '0);
    rd_gnt    = (rst || hazard || (full && !ram_data_valid)) ? 2'b00 : rd_cand;
    push      = |rd_gnt;
    wptr_d    = wptr_q;
    if (wr_gnt[0]) wptr_d = 1'b1;
    if (wr_gnt[1]) wptr_d = 1'b0;
    rptr_d    = rptr_q;
    if (rd_gnt[0]) rptr_d = 1'b1;
    if (rd_gnt[1]) rptr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      ram_write_q <= 1'b0;
      ram_read_q  <= 1'b0;
      wa_q        <= '0;
      wd_q        <= '0;
      ra_q        <= '0;
      rsp_vld_q   <= 2'b00;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_q[i] <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_write_q <= |wr_gnt;
      ram_read_q  <= push;
      if (|wr_gnt) begin
        wa_q <= wsel_addr;
        wd_q <= wr_gnt[1] ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
      end
      if (push) begin
        ra_q        <= rsel_addr;
        tag_q[wp_q] <= rd_gnt[1];
        wp_q        <= wp_q + PW'(1);
      end
      rsp_vld_q <= pop ? {tag_q[rp_q], ~tag_q[rp_q]} : 2'b00;
      if (pop) begin
        rsp_data_q <= ram_data_out;
        rp_q       <= rp_q + PW'(1);
      end
      if (ram_data_valid && cnt_q == '0) rsp_err_q <= 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ram_write      = ram_write_q;
  assign ram_wr_address = wa_q;
  assign ram_data_in    = wd_q;
  assign ram_read       = ram_read_q;
  assign ram_rd_address = ra_q;
  assign rd_rsp_valid   = rsp_vld_q;
  assign rd_rsp_data    = rsp_data_q;
  assign rsp_err        = rsp_err_q;
endmodule

// File: tb/tb_ram_4k_arbiter.sv
// Directed-vector bench for ram_4k_arbiter; the bench plays the RAM by
// driving ram_data_out/ram_data_valid with hand-chosen values.
module tb_ram_4k_arbiter;
  logic         clk = 1'b0, rst;
  logic [1:0]   wr_req, wr_gnt, rd_req, rd_gnt, rd_rsp_valid;
  logic [23:0]  wr_addr, rd_addr;
  logic [127:0] wr_data;
  logic [63:0]  rd_rsp_data, ram_data_in, ram_data_out;
  logic         ram_write, ram_read, ram_data_valid, rsp_err;
  logic [11:0]  ram_wr_address, ram_rd_address;
  int           n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  ram_4k_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .ram_write(ram_write), .ram_wr_address(ram_wr_address), .ram_data_in(ram_data_in),
    .ram_read(ram_read), .ram_rd_address(ram_rd_address),
    .ram_data_out(ram_data_out), .ram_data_valid(ram_data_valid), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; wr_req = 2'b11; rd_req = 2'b00; ram_data_valid = 1'b0;
    wr_addr = {12'h820, 12'h010}; rd_addr = '0; ram_data_out = '0;
    wr_data = {64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    #12;
    chk("rst_wgnt", 64'(wr_gnt), 64'h0);
    chk("rst_wen", 64'(ram_write), 64'h0);
    chk("rst_ren", 64'(ram_read), 64'h0);
    chk("rst_waddr", 64'(ram_wr_address), 64'h0);
    chk("rst_rvld", 64'(rd_rsp_valid), 64'h0);
    chk("rst_err", 64'(rsp_err), 64'h0);
    @(posedge clk); #1 rst = 1'b0;

    // both writers held: alternate grants
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_wgnt", 64'(wr_gnt), (k % 2) ? 64'h2 : 64'h1);
      tick;
      chk("rr_wen", 64'(ram_write), 64'h1);
      chk("rr_waddr", 64'(ram_wr_address), (k % 2) ? 64'h820 : 64'h010);
    end
    wr_req = 2'b00;
    tick;
    chk("idle_wen", 64'(ram_write), 64'h0);
    chk("hold_waddr", 64'(ram_wr_address), 64'h820);

    // requester 1 writes then reads 0xC05
    wr_req = 2'b10; wr_addr[23:12] = 12'hC05; wr_data[127:64] = 64'hDEADBEEF_00000001;
    #1 chk("w1_gnt", 64'(wr_gnt), 64'h2);
    tick; wr_req = 2'b00;
    chk("w1_addr", 64'(ram_wr_address), 64'hC05);
    chk("w1_data", ram_data_in, 64'hDEADBEEF_00000001);
    rd_req = 2'b10; rd_addr = {12'hC05, 12'h000};
    #1 chk("r1_gnt", 64'(rd_gnt), 64'h2);
    tick; rd_req = 2'b00;
    chk("r1_ren", 64'(ram_read), 64'h1);
    chk("r1_raddr", 64'(ram_rd_address), 64'hC05);
    ram_data_valid = 1'b1; ram_data_out = 64'hDEADBEEF_00000001;
    tick; ram_data_valid = 1'b0;
    chk("r1_rvld", 64'(rd_rsp_valid), 64'h2);
    chk("r1_rdata", rd_rsp_data, 64'hDEADBEEF_00000001);
    tick;
    chk("r1_rvld_off", 64'(rd_rsp_valid), 64'h0);
    chk("r1_rdata_hold", rd_rsp_data, 64'hDEADBEEF_00000001);

    // fill the tag FIFO: four grants, then stall until a pop
    rd_req = 2'b01; rd_addr[11:0] = 12'h100;
    for (int k = 0; k < 6; k++) begin
      #1 chk("fill_rgnt", 64'(rd_gnt), (k < 4) ? 64'h1 : 64'h0);
      tick;
    end
    ram_data_valid = 1'b1; ram_data_out = 64'h55;
    #1 chk("popfull_rgnt", 64'(rd_gnt), 64'h1);
    tick; ram_data_valid = 1'b0;
    chk("popfull_rvld", 64'(rd_rsp_valid), 64'h1);
    chk("popfull_rdata", rd_rsp_data, 64'h55);
    #1 chk("refull_rgnt", 64'(rd_gnt), 64'h0);
    rd_req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      ram_data_valid = 1'b1; ram_data_out = 64'(k + 'h60);
      tick;
      chk("drain_rvld", 64'(rd_rsp_valid), 64'h1);
      chk("drain_rdata", rd_rsp_data, 64'(k + 'h60));
    end
    ram_data_valid = 1'b0;

    // both readers: pointer points at 1 after requester-0 grants; responses in order
    rd_req = 2'b11; rd_addr = {12'h200, 12'h201};
    #1 chk("rr_rgnt0", 64'(rd_gnt), 64'h2);
    tick;
    #1 chk("rr_rgnt1", 64'(rd_gnt), 64'h1);
    tick; rd_req = 2'b00;
    ram_data_valid = 1'b1; ram_data_out = 64'h70;
    tick;
    chk("ord_rvld0", 64'(rd_rsp_valid), 64'h2);
    chk("ord_rdata0", rd_rsp_data, 64'h70);
    ram_data_out = 64'h71;
    tick; ram_data_valid = 1'b0;
    chk("ord_rvld1", 64'(rd_rsp_valid), 64'h1);
    chk("ord_rdata1", rd_rsp_data, 64'h71);

    // same-address write/read: read stalls one cycle
    wr_req = 2'b01; wr_addr[11:0] = 12'h3FF; rd_req = 2'b01; rd_addr[11:0] = 12'h3FF;
    #1 chk("haz_wgnt", 64'(wr_gnt), 64'h1);
    chk("haz_rgnt", 64'(rd_gnt), 64'h0);
    tick; wr_req = 2'b00;
    chk("haz_wen", 64'(ram_write), 64'h1);
    chk("haz_ren", 64'(ram_read), 64'h0);
    #1 chk("haz_rgnt2", 64'(rd_gnt), 64'h1);
    tick; rd_req = 2'b00;
    chk("haz_ren2", 64'(ram_read), 64'h1);
    chk("haz_raddr", 64'(ram_rd_address), 64'h3FF);
    chk("haz_wen2", 64'(ram_write), 64'h0);
    ram_data_valid = 1'b1; ram_data_out = 64'h3F;
    tick; ram_data_valid = 1'b0;
    chk("haz_rvld", 64'(rd_rsp_valid), 64'h1);
    chk("pre_err", 64'(rsp_err), 64'h0);

    // stray RAM return with nothing outstanding
    ram_data_valid = 1'b1; ram_data_out = 64'h99;
    tick; ram_data_valid = 1'b0;
    chk("err_set", 64'(rsp_err), 64'h1);
    chk("err_rvld", 64'(rd_rsp_valid), 64'h0);
    tick;
    chk("err_sticky", 64'(rsp_err), 64'h1);

    // async reset mid-stream
    wr_req = 2'b01; wr_addr[11:0] = 12'h123;
    tick;
    chk("pre_rst_wen", 64'(ram_write), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wen", 64'(ram_write), 64'h0);
    chk("arst_waddr", 64'(ram_wr_address), 64'h0);
    chk("arst_rdata", rd_rsp_data, 64'h0);
    chk("arst_err", 64'(rsp_err), 64'h0);
    chk("arst_wgnt", 64'(wr_gnt), 64'h0);
    wr_req = 2'b00;
    tick; rst = 1'b0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_4k_arbiter.md
RAM_4K_ARBITER -- requirements
Module: ram_4k_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 12, RAM address width (4K words).
REQ-003 SHALL have parameter TAG_DEPTH, default 4, max outstanding reads (power of 2, ≥2).
REQ-004 SHALL have port clk  in  1  single clock; also drives the RAM.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wr_req  in  2  write request, bit i = requester i.
REQ-007 SHALL have port wr_addr  in  2*ADDR_W  write address, slice i = requester i.
REQ-008 SHALL have port wr_data  in  2*DATA_W  write data, slice i = requester i.
REQ-009 SHALL have port wr_gnt  out  2  write accepted this cycle (combinational).
REQ-010 SHALL have port rd_req  in  2  read request per requester.
REQ-011 SHALL have port rd_addr  in  2*ADDR_W  read address per requester.
REQ-012 SHALL have port rd_gnt  out  2  read accepted this cycle (combinational).
REQ-013 SHALL have port rd_rsp_valid  out  2  one-cycle read response strobe per requester (registered).
REQ-014 SHALL have port rd_rsp_data  out  DATA_W  read response data, shared (registered).
REQ-015 SHALL have port ram_write / ram_wr_address / ram_data_in  out  1/ADDR_W/DATA_W  RAM write port (registered).
REQ-016 SHALL have port ram_read / ram_rd_address  out  1/ADDR_W  RAM read port (registered).
REQ-017 SHALL have port ram_data_out / ram_data_valid  in  DATA_W/1  RAM read return.
REQ-018 SHALL have port rsp_err  out  1  sticky: RAM return arrived with no outstanding read.

Function
REQ-019 Write and read arbiters SHALL operate independently in the same cycle (dual-port).
REQ-020 Each arbiter SHALL be round-robin with a 1-bit pointer: both requesting -> grant the pointer's requester; one requesting -> grant it; after any grant, pointer = other requester.
REQ-021 A transfer SHALL occur when req[i] & gnt[i] at a rising clk edge; at most one gnt bit per arbiter per cycle; gnt never asserted without req.
REQ-022 Accepted write SHALL drive ram_write=1 with granted address/data the next cycle; otherwise ram_write=0 with address/data holding last values.
REQ-023 Accepted read SHALL drive ram_read=1 with granted address the next cycle and push requester ID into the tag FIFO.
REQ-024 Read grant SHALL be withheld while tag FIFO is full, unless a pop (ram_data_valid) occurs in the same cycle.
REQ-025 Hazard: read candidate address equal to the write address being granted the same cycle SHALL stall the read one cycle (rd_gnt=0, pointer unchanged); write proceeds.
REQ-026 On ram_data_valid with FIFO non-empty: pop tag T; next cycle rd_rsp_valid[T]=1 for one cycle, rd_rsp_data=ram_data_out; rd_rsp_data holds otherwise.
REQ-027 On ram_data_valid with FIFO empty: no response, rsp_err set to 1 and held until reset.
REQ-028 Simultaneous push and pop SHALL keep occupancy unchanged; FIFO pointers wrap modulo TAG_DEPTH.
REQ-029 Responses SHALL return in issue order; no reordering or forwarding.

Reset
REQ-030 On rst=1 (any cycle, asynchronously): ram_write=0, ram_read=0, all addresses/data=0, rd_rsp_valid=0, rd_rsp_data=0, both pointers=0, tag FIFO empty, rsp_err=0; gnt outputs SHALL be 0 while rst=1.
REQ-031 Reads in flight at reset SHALL be discarded; their late RAM returns set rsp_err (system holds rst ≥ TAG_DEPTH+RAM latency cycles to avoid this).

Verification
REQ-032 Both wr_req=2'b11 held 4 cycles, addrs 0x010/0x820 -> wr_gnt 01,10,01,10; ram_wr_address 0x010,0x820,0x010,0x820 one cycle later.
REQ-033 Requester 1 reads 0xC05 after writing 0xDEADBEEF_00000001 there -> rd_rsp_valid=2'b10, rd_rsp_data=0xDEADBEEF_00000001; rd_rsp_valid[0] stays 0.
REQ-034 rd_req=2'b01 every cycle, ram_data_valid held 0 -> exactly 4 rd_gnt then rd_gnt=0; one ram_data_valid pulse -> one further grant same cycle.
REQ-035 Write and read both to 0x3FF same cycle -> wr_gnt set, rd_gnt=0, read granted next cycle; ram_read follows ram_write by one cycle.
REQ-036 ram_data_valid pulse with no reads issued -> rsp_err=1, rd_rsp_valid=0; rst pulse mid-stream -> all outputs 0 immediately, rsp_err=0.
